// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch unit, the memory unit, the arbiter and the unified memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_cancel_i;
  logic [31:0] i_rdata_o;
  logic        i_valid_o;
  logic        i_busy_o;

  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wmask_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        d_busy_o;

  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, i_cancel_i, d_req_i, d_addr_i, d_wdata_i, d_wmask_i, mem_rdata_i,
    output i_rdata_o, i_valid_o, i_busy_o, d_rdata_o, d_valid_o, d_busy_o,
           mem_en_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );

  modport master (
    output i_req_i, i_addr_i, i_cancel_i, d_req_i, d_addr_i, d_wdata_i, d_wmask_i, mem_rdata_i,
    input  i_rdata_o, i_valid_o, i_busy_o, d_rdata_o, d_valid_o, d_busy_o,
           mem_en_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory (IDLE/ISSUE/WAIT/RESP),
// data first, with a starvation guard that forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_e;

  state_e                state_q;
  owner_e                owner_q;
  logic [LAT_W-1:0]      lat_cnt_q;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  cancelled_q;
  logic                  mem_en_q;
  logic [31:0]           mem_addr_q, mem_wdata_q;
  logic [3:0]            mem_wmask_q;

  logic starved, grant_fetch, fetch_cancel;
  logic i_valid, d_valid;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    starved      = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    grant_fetch  = bus.i_req_i && (!bus.d_req_i || starved);
    starve_cnt_d = '0;
    if (!grant_fetch && bus.i_req_i) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  assign fetch_cancel = bus.i_cancel_i && (owner_q == OWNER_FETCH);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_FETCH;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cancelled_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees only pre-edge values.
      mem_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cancelled_q <= 1'b0;
          if (bus.i_req_i || bus.d_req_i) begin
            state_q      <= ISSUE;
            mem_en_q     <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            if (grant_fetch) begin
              owner_q     <= OWNER_FETCH;
              mem_addr_q  <= bus.i_addr_i;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end else begin
              owner_q     <= OWNER_DATA;
              mem_addr_q  <= bus.d_addr_i;
              mem_wdata_q <= bus.d_wdata_i;
              mem_wmask_q <= bus.d_wmask_i;
            end
          end
        end
        ISSUE: begin
          lat_cnt_q <= LAT_W'(MEM_LATENCY - 1);
          state_q   <= (MEM_LATENCY == 1) ? RESP : WAIT;
          if (fetch_cancel) cancelled_q <= 1'b1;
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          if (lat_cnt_q == LAT_W'(1)) state_q <= RESP;
          if (fetch_cancel) cancelled_q <= 1'b1;
        end
        RESP: begin
          state_q     <= IDLE;
          cancelled_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A cancel arriving in the RESP cycle itself must still suppress the strobe.
  assign i_valid = (state_q == RESP) && (owner_q == OWNER_FETCH) && !cancelled_q && !bus.i_cancel_i;
  assign d_valid = (state_q == RESP) && (owner_q == OWNER_DATA);

  assign bus.i_valid_o   = i_valid;
  assign bus.d_valid_o   = d_valid;
  assign bus.i_rdata_o   = i_valid ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = (d_valid && (mem_wmask_q == '0)) ? bus.mem_rdata_i : '0;
  assign bus.i_busy_o    = bus.i_req_i && !i_valid;
  assign bus.d_busy_o    = bus.d_req_i && !d_valid;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wmask_o = mem_wmask_q;
endmodule
